// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback source, extracts and extends load data,
// and registers the result with one cycle of latency. Also keeps a saturating retire count.
module wb_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [1:0]            in_wb_sel,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_read_data,
   input  logic [DATA_W-1:0]     in_link_addr,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_reg_write,
   input  logic [1:0]            in_ld_size,
   input  logic                  in_ld_unsigned,
   input  logic [1:0]            in_byte_off,
   output logic [DATA_W-1:0]     wb_data,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_we,
   output logic                  wb_valid,
   output logic [CNT_W-1:0]      retire_count
);

   typedef enum logic [1:0] {
      SEL_ALU  = 2'b00,
      SEL_MEM  = 2'b01,
      SEL_LINK = 2'b10,
      SEL_ALU2 = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      LD_BYTE = 2'b00,
      LD_HALF = 2'b01,
      LD_WORD = 2'b10,
      LD_FULL = 2'b11
   } ld_size_e;

   logic [7:0]          byte_lane;
   logic [15:0]         half_lane;
   logic [DATA_W-1:0]   mem_value;
   logic [DATA_W-1:0]   wb_data_nxt;
   logic                wb_we_nxt;
   logic                wb_valid_nxt;
   logic                capture;
   logic                retire;
   logic                cnt_full;

   // Little-endian lane selection; the half lane ignores the low offset bit.
   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      byte_lane = in_read_data[7:0];
      case (in_byte_off)
         2'd0: byte_lane = in_read_data[7:0];
         2'd1: byte_lane = in_read_data[15:8];
         2'd2: byte_lane = in_read_data[23:16];
         2'd3: byte_lane = in_read_data[31:24];
         default: byte_lane = in_read_data[7:0];
      endcase
      half_lane = in_byte_off[1] ? in_read_data[31:16] : in_read_data[15:0];
   end

   // Fill with the extension bit, then overlay the loaded field; this avoids a
   // zero-width replication when DATA_W is exactly 32.
   always_comb begin
      mem_value = in_read_data;
      case (ld_size_e'(in_ld_size))
         LD_BYTE: begin
            mem_value      = {DATA_W{~in_ld_unsigned & byte_lane[7]}};
            mem_value[7:0] = byte_lane;
         end
         LD_HALF: begin
            mem_value       = {DATA_W{~in_ld_unsigned & half_lane[15]}};
            mem_value[15:0] = half_lane;
         end
         LD_WORD: begin
            mem_value       = {DATA_W{~in_ld_unsigned & in_read_data[31]}};
            mem_value[31:0] = in_read_data[31:0];
         end
         LD_FULL: mem_value = in_read_data;
         default: mem_value = in_read_data;
      endcase
   end

   always_comb begin
      wb_data_nxt = in_alu_result;
      case (wb_sel_e'(in_wb_sel))
         SEL_ALU:  wb_data_nxt = in_alu_result;
         SEL_MEM:  wb_data_nxt = mem_value;
         SEL_LINK: wb_data_nxt = in_link_addr;
         SEL_ALU2: wb_data_nxt = in_alu_result;
         default:  wb_data_nxt = in_alu_result;
      endcase
   end

   // Flush overrides stall: the stage still loads, but as a bubble.
   assign capture      = ~stall | flush;
   assign wb_valid_nxt = in_valid & ~flush;
   assign wb_we_nxt    = in_valid & in_reg_write & (in_rd != '0) & ~flush;
   assign retire       = ~stall & ~flush & in_valid;
   assign cnt_full     = (retire_count == {CNT_W{1'b1}});

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_data  <= '0;
         wb_rd    <= '0;
         wb_we    <= 1'b0;
         wb_valid <= 1'b0;
      end else if (capture) begin
         wb_data  <= wb_data_nxt;
         wb_rd    <= in_rd;
         wb_we    <= wb_we_nxt;
         wb_valid <= wb_valid_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_count <= '0;
      end else if (retire && !cnt_full) begin
         retire_count <= retire_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: a vector table of single-cycle captures plus
// hand-written stall/flush, saturation and reset sequences.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, stall, flush;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_alu_result, in_read_data, in_link_addr;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic [1:0]  in_ld_size;
   logic        in_ld_unsigned;
   logic [1:0]  in_byte_off;

   logic [31:0] wb_data, s_wb_data;
   logic [4:0]  wb_rd, s_wb_rd;
   logic        wb_we, s_wb_we, wb_valid, s_wb_valid;
   logic [15:0] retire_count;
   logic [3:0]  s_retire_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_read_data(in_read_data),
      .in_link_addr(in_link_addr), .in_rd(in_rd), .in_reg_write(in_reg_write),
      .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_byte_off(in_byte_off),
      .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .wb_valid(wb_valid),
      .retire_count(retire_count)
   );

   wb_stage #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_read_data(in_read_data),
      .in_link_addr(in_link_addr), .in_rd(in_rd), .in_reg_write(in_reg_write),
      .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_byte_off(in_byte_off),
      .wb_data(s_wb_data), .wb_rd(s_wb_rd), .wb_we(s_wb_we), .wb_valid(s_wb_valid),
      .retire_count(s_retire_count)
   );

   typedef struct {
      string       name;
      logic        valid, stall, flush;
      logic [1:0]  sel;
      logic [31:0] alu, rdata, link;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  off;
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;
      logic        exp_we, exp_valid;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic st, input logic fl, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] link,
                        input logic [4:0] rd, input logic rw, input logic [1:0] size,
                        input logic uns, input logic [1:0] off);
      in_valid = v; stall = st; flush = fl; in_wb_sel = sel;
      in_alu_result = alu; in_read_data = rdata; in_link_addr = link;
      in_rd = rd; in_reg_write = rw; in_ld_size = size; in_ld_unsigned = uns; in_byte_off = off;
   endtask

   task automatic check_outs(input string tag, input logic [31:0] d, input logic [4:0] r,
                             input logic we, input logic v, input logic [15:0] c);
      check({tag, ".data"},  64'(wb_data),      64'(d));
      check({tag, ".rd"},    64'(wb_rd),        64'(r));
      check({tag, ".we"},    64'(wb_we),        64'(we));
      check({tag, ".valid"}, 64'(wb_valid),     64'(v));
      check({tag, ".count"}, 64'(retire_count), 64'(c));
   endtask

   initial begin
      //          name        v  st fl sel    alu           rdata         link          rd rw size  u  off   exp_data      rd we v  cnt
      vecs[0]  = '{"alu",     1, 0, 0, 2'b00, 32'd42,       32'h0,        32'h0,        3, 1, 2'b00, 0, 2'd0, 32'd42,       3, 1, 1, 16'd1};
      vecs[1]  = '{"lb_o3_s", 1, 0, 0, 2'b01, 32'h0,        32'h80FF7F01, 32'h0,        5, 1, 2'b00, 0, 2'd3, 32'hFFFFFF80, 5, 1, 1, 16'd2};
      vecs[2]  = '{"lb_o3_u", 1, 0, 0, 2'b01, 32'h0,        32'h80FF7F01, 32'h0,        5, 1, 2'b00, 1, 2'd3, 32'h00000080, 5, 1, 1, 16'd3};
      vecs[3]  = '{"lb_o0_s", 1, 0, 0, 2'b01, 32'h0,        32'h80FF7F01, 32'h0,        5, 1, 2'b00, 0, 2'd0, 32'h00000001, 5, 1, 1, 16'd4};
      vecs[4]  = '{"lb_o1_s", 1, 0, 0, 2'b01, 32'h0,        32'h80FF7F01, 32'h0,        5, 1, 2'b00, 0, 2'd1, 32'h0000007F, 5, 1, 1, 16'd5};
      vecs[5]  = '{"lb_o2_s", 1, 0, 0, 2'b01, 32'h0,        32'h80FF7F01, 32'h0,        5, 1, 2'b00, 0, 2'd2, 32'hFFFFFFFF, 5, 1, 1, 16'd6};
      vecs[6]  = '{"lh_o2_s", 1, 0, 0, 2'b01, 32'h0,        32'h9ABC1234, 32'h0,        6, 1, 2'b01, 0, 2'd2, 32'hFFFF9ABC, 6, 1, 1, 16'd7};
      vecs[7]  = '{"lh_o3_s", 1, 0, 0, 2'b01, 32'h0,        32'h9ABC1234, 32'h0,        6, 1, 2'b01, 0, 2'd3, 32'hFFFF9ABC, 6, 1, 1, 16'd8};
      vecs[8]  = '{"lh_o2_u", 1, 0, 0, 2'b01, 32'h0,        32'h9ABC1234, 32'h0,        6, 1, 2'b01, 1, 2'd2, 32'h00009ABC, 6, 1, 1, 16'd9};
      vecs[9]  = '{"lh_o1_s", 1, 0, 0, 2'b01, 32'h0,        32'h9ABC1234, 32'h0,        6, 1, 2'b01, 0, 2'd1, 32'h00001234, 6, 1, 1, 16'd10};
      vecs[10] = '{"lw",      1, 0, 0, 2'b01, 32'h0,        32'h89ABCDEF, 32'h0,        7, 1, 2'b10, 1, 2'd0, 32'h89ABCDEF, 7, 1, 1, 16'd11};
      vecs[11] = '{"sel11",   1, 0, 0, 2'b11, 32'h00001234, 32'h000000FF, 32'h0,        7, 1, 2'b00, 0, 2'd0, 32'h00001234, 7, 1, 1, 16'd12};
      vecs[12] = '{"rd0",     1, 0, 0, 2'b00, 32'd7,        32'h0,        32'h0,        0, 1, 2'b00, 0, 2'd0, 32'd7,        0, 0, 1, 16'd13};
      vecs[13] = '{"link",    1, 0, 0, 2'b10, 32'd1,        32'h0,        32'h00400008, 1, 1, 2'b00, 0, 2'd0, 32'h00400008, 1, 1, 1, 16'd14};
      vecs[14] = '{"invalid", 0, 0, 0, 2'b00, 32'd9,        32'h0,        32'h0,        4, 1, 2'b00, 0, 2'd0, 32'd9,        4, 0, 0, 16'd14};
      vecs[15] = '{"flush",   1, 0, 1, 2'b00, 32'd55,       32'h0,        32'h0,        7, 1, 2'b00, 0, 2'd0, 32'd55,       7, 0, 0, 16'd14};

      // Reset state
      rst = 1'b1;
      drive(1, 0, 0, 2'b00, 32'hDEAD, 32'h0, 32'h0, 5'd9, 1, 2'b00, 0, 2'd0);
      step();
      step();
      check_outs("reset", 32'h0, 5'd0, 0, 0, 16'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].sel, vecs[i].alu,
               vecs[i].rdata, vecs[i].link, vecs[i].rd, vecs[i].rw, vecs[i].size,
               vecs[i].uns, vecs[i].off);
         step();
         check_outs(vecs[i].name, vecs[i].exp_data, vecs[i].exp_rd, vecs[i].exp_we,
                    vecs[i].exp_valid, vecs[i].exp_cnt);
      end

      // Stall holds, flush overrides stall
      drive(1, 0, 0, 2'b00, 32'd120, 32'h0, 32'h0, 5'd8, 1, 2'b00, 0, 2'd0);
      step();
      check_outs("cap120", 32'd120, 5'd8, 1, 1, 16'd15);
      drive(1, 1, 0, 2'b00, 32'd300, 32'h0, 32'h0, 5'd9, 1, 2'b00, 0, 2'd0);
      step();
      check_outs("stall1", 32'd120, 5'd8, 1, 1, 16'd15);
      step();
      check_outs("stall2", 32'd120, 5'd8, 1, 1, 16'd15);
      flush = 1'b1;
      step();
      check_outs("flush_stall", 32'd300, 5'd9, 0, 0, 16'd15);
      flush = 1'b0;
      in_alu_result = 32'd777;
      step();
      check_outs("stall_after_flush", 32'd300, 5'd9, 0, 0, 16'd15);

      // Saturation on the 4-bit counter instance
      rst = 1'b1;
      stall = 1'b0;
      step();
      check("sat.reset", 64'(s_retire_count), 64'd0);
      rst = 1'b0;
      drive(1, 0, 0, 2'b00, 32'd1, 32'h0, 32'h0, 5'd2, 1, 2'b00, 0, 2'd0);
      for (int n = 1; n <= 17; n++) begin
         step();
         if (n == 14) check("sat.n14", 64'(s_retire_count), 64'd14);
         if (n == 15) check("sat.n15", 64'(s_retire_count), 64'd15);
         if (n == 16) check("sat.n16", 64'(s_retire_count), 64'd15);
      end
      check("sat.n17", 64'(s_retire_count), 64'd15);
      check("wide.n17", 64'(retire_count), 64'd17);

      // Reset during stall clears everything; next edge captures normally
      stall = 1'b1;
      rst = 1'b1;
      step();
      check_outs("rst_stall", 32'h0, 5'd0, 0, 0, 16'd0);
      check("sat.rst_stall.count", 64'(s_retire_count), 64'd0);
      check("sat.rst_stall.data",  64'(s_wb_data),      64'd0);
      check("sat.rst_stall.ctl",   64'({s_wb_rd, s_wb_we, s_wb_valid}), 64'd0);
      rst = 1'b0;
      drive(1, 0, 0, 2'b00, 32'd5, 32'h0, 32'h0, 5'd2, 1, 2'b00, 0, 2'd0);
      step();
      check_outs("post_rst", 32'd5, 5'd2, 1, 1, 16'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be >= 32.
REQ-002 Parameter REG_ADDR_W, default 5, destination register index width.
REQ-003 Parameter CNT_W, default 16, retire counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  MEM stage presents a valid instruction.
REQ-007 stall  input  1  hold all stage state this cycle.
REQ-008 flush  input  1  discard the incoming instruction and insert a bubble.
REQ-009 in_wb_sel  input  2  00 ALU, 01 memory, 10 link, 11 ALU.
REQ-010 in_alu_result  input  DATA_W  ALU result.
REQ-011 in_read_data  input  DATA_W  raw memory read data.
REQ-012 in_link_addr  input  DATA_W  return address for jal/jalr.
REQ-013 in_rd  input  REG_ADDR_W  destination register.
REQ-014 in_reg_write  input  1  instruction writes the register file.
REQ-015 in_ld_size  input  2  00 byte, 01 half, 10 word (32b), 11 full DATA_W.
REQ-016 in_ld_unsigned  input  1  zero-extend (1) or sign-extend (0) the loaded value.
REQ-017 in_byte_off  input  2  low address bits selecting the byte or half lane.
REQ-018 wb_data  output  DATA_W  registered writeback data.
REQ-019 wb_rd  output  REG_ADDR_W  registered destination register.
REQ-020 wb_we  output  1  register-file write enable.
REQ-021 wb_valid  output  1  registered instruction-valid flag.
REQ-022 retire_count  output  CNT_W  count of retired instructions.

Function
REQ-023 Latency SHALL be exactly one cycle; inputs are selected and extended combinationally, then captured into output registers.
REQ-024 Capture: when stall=0, the stage SHALL load wb_data, wb_rd and wb_valid from the current inputs.
REQ-025 Capture: when stall=0, wb_valid SHALL load in_valid AND NOT flush.
REQ-026 Stall: when stall=1 and flush=0, all outputs and retire_count SHALL hold their values.
REQ-027 Flush priority: when flush=1, flush SHALL take priority over stall; wb_valid SHALL become 0 and wb_we SHALL become 0.
REQ-028 Flush data: on flush, wb_data and wb_rd SHALL still capture the current inputs.
REQ-029 Reset priority: rst SHALL take priority over flush and stall.
REQ-030 Write enable: wb_we SHALL be registered as in_valid AND in_reg_write AND (in_rd != 0) AND NOT flush; it SHALL never assert for register 0.
REQ-031 Source select: wb_sel 00 and 11 SHALL select the ALU result, 01 the extended memory value, 10 the link address.
REQ-032 Byte lane: a byte load SHALL take in_read_data[8*off+7 : 8*off], where off = in_byte_off (little-endian).
REQ-033 Half lane: a half load SHALL take bits [31:16] when in_byte_off[1]=1, else bits [15:0]; in_byte_off[0] SHALL be ignored.
REQ-034 Word load: SHALL take bits [31:0].
REQ-035 Full load: in_ld_size=11 SHALL pass all DATA_W bits unmodified.
REQ-036 Extension: byte, half and word results SHALL be sign- or zero-extended to DATA_W per in_ld_unsigned.
REQ-037 Extension scope: extension SHALL apply only when in_wb_sel=01.
REQ-038 Retire counter: retire_count SHALL increment by 1 on each edge where rst=0, stall=0, flush=0 and in_valid=1.
REQ-039 Counter saturation: retire_count SHALL saturate at all-ones and SHALL NOT wrap.

Reset
REQ-040 With rst=1 at an edge: wb_data=0, wb_rd=0, wb_we=0, wb_valid=0, retire_count=0.
REQ-041 Reset mid-stall SHALL clear state identically, and the first edge after reset deasserts SHALL capture normally.

Verification
REQ-042 ALU select: sel=00, alu=42, rd=3, reg_write=1, valid=1 -> next cycle wb_data=42, wb_rd=3, wb_we=1, retire_count=1.
REQ-043 Byte sign-extension: sel=01, read=0x80FF7F01, size=00, off=3, unsigned=0 -> wb_data=0xFFFFFF80; same with unsigned=1 -> 0x00000080.
REQ-044 Half extraction: size=01, off=2, read=0x9ABC1234, unsigned=0 -> 0xFFFF9ABC; off=3 gives the same result.
REQ-045 Stall then flush: capture alu=120, then stall=1 with alu=300 for 2 cycles -> wb_data stays 120 and count unchanged; then flush=1 with stall=1 -> wb_valid=0, wb_we=0, count unchanged.
REQ-046 Register-0 write and link: rd=0, reg_write=1 -> wb_we=0 while count still increments; sel=10, link=0x00400008 -> wb_data=0x00400008.
REQ-047 Saturation and reset: with CNT_W=4, 17 valid instructions -> retire_count=15; then rst=1 during stall=1 -> all outputs 0 next edge.
